reg_mem_cmd_sequencer: RTL and testbench
========================================

// Module: reg_mem_cmd_sequencer
// PURPOSE
//  Upstream command stage for the register-bank/block-memory unit.
//  - Buffers (opcode, reg_addr, mem_addr, data) commands in a small FIFO.
//  - Issues them one at a time, holding fields stable for the block-RAM latency.
//  - Captures read data for opcodes 2 and 3 and returns it on a valid/ready response port.
// PARAMETERS
//  DEPTH     4  command FIFO entries; power of 2, >=2
//  HOLD_CYC  2  cycles fields stay stable after issue (BRAM read latency + 1); >=1
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  cmd_valid     in   1   command present
//  cmd_ready     out  1   FIFO not full; command accepted when cmd_valid&cmd_ready
//  cmd_opcode    in   2   0 data->mem, 1 reg->mem, 2 mem->reg, 3 display mem
//  cmd_reg_addr  in   3   register index
//  cmd_mem_addr  in   4   memory word address
//  cmd_data      in   32  immediate data (opcode 0)
//  opcode        out  2   to unit; held stable while busy
//  reg_addr      out  3   to unit
//  mem_addr      out  4   to unit
//  data          out  32  to unit
//  issue         out  1   one-cycle strobe: new command presented on opcode..data
//  busy          out  1   command in flight (ISSUE, WAIT or RESP)
//  data_out      in   32  read data returned by unit's memory port
//  rsp_valid     out  1   response available (opcodes 2/3 only)
//  rsp_ready     in   1   response consumer ready
//  rsp_opcode    out  2   opcode the response belongs to
//  rsp_data      out  32  captured data_out
//  cmd_count     out  16  completed commands, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; FSM IDLE.
//    - cmd_ready rises 0 in the first cycle after rst deasserts... correction: cmd_ready=1 once rst is low.
//    - rst mid-operation aborts the in-flight command and flushes the FIFO; no rsp is produced.
//  - FIFO:
//    - Write on cmd_valid&cmd_ready; cmd_ready = !full.
//    - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//    - Simultaneous push and pop when full is not allowed: cmd_ready is low when full.
//    - Simultaneous push and pop when non-full keeps the count unchanged.
//  - FSM:
//    - IDLE: if FIFO non-empty, pop the head, register it onto opcode..data, go to ISSUE.
//    - ISSUE: issue=1 for exactly this cycle; load wait counter = HOLD_CYC-1; go to WAIT.
//    - WAIT: decrement the counter. When it reaches 0:
//      - opcode 0/1: increment cmd_count, go to IDLE.
//      - opcode 2/3: rsp_data<=data_out, rsp_opcode<=opcode, rsp_valid<=1, go to RESP.
//    - RESP: hold until rsp_valid&rsp_ready, then rsp_valid<=0, increment cmd_count, go to IDLE.
//  - Latency:
//    - Accept to issue, with FIFO empty and IDLE: 2 cycles.
//    - Issue to rsp_valid: HOLD_CYC+1 cycles.
//    - Back-to-back write commands: one issue every HOLD_CYC+2 cycles.
//  - Stability: opcode..data change only on the IDLE->ISSUE transition; they hold their last value while idle.
//  - busy = (state != IDLE).
//  - cmd_count does not wrap; it stays at 16'hFFFF once reached.
// TESTING
//  1. rst held 5 cycles, then released.
//     -> All outputs 0; cmd_ready=1 after release.
//  2. Push {op0, mem 1, data 10}.
//     -> issue pulses once, 2 cycles after accept, with mem_addr=1, data=10.
//     -> No rsp; cmd_count=1 after HOLD_CYC+1 more cycles.
//  3. Push {op3, mem 1}, with the model returning data_out=10 during hold.
//     -> rsp_valid=1 with rsp_opcode=3, rsp_data=10.
//     -> Hold rsp_ready=0 for 5 cycles: rsp stable, busy=1, no new issue.
//  4. Push 5 commands with cmd_valid held high while the sequencer is busy (DEPTH=4).
//     -> cmd_ready drops after the 4th command is buffered.
//     -> All 5 commands are issued in order, identified by mem_addr 0..4.
//  5. Assert rst during WAIT of an op2 command.
//     -> All outputs 0 immediately (async); FIFO empty.
//     -> No rsp after release; cmd_count=0.
//  6. Preload cmd_count=16'hFFFE via force, then complete 3 commands.
//     -> cmd_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/reg_mem_cmd_sequencer_if.sv
// Command and response handshake bundle between a command producer and the sequencer.
interface reg_mem_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_opcode;
   logic [2:0]  cmd_reg_addr;
   logic [3:0]  cmd_mem_addr;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_opcode;
   logic [31:0] rsp_data;

   modport master (
      output cmd_valid, cmd_opcode, cmd_reg_addr, cmd_mem_addr, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_opcode, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_reg_addr, cmd_mem_addr, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_opcode, rsp_data
   );
endinterface

// File: rtl/reg_mem_cmd_sequencer.sv
// Buffers register/memory commands, issues them one at a time with fields held for
// the BRAM latency, and returns captured read data for opcodes 2/3.
module reg_mem_cmd_sequencer #(
   parameter int DEPTH    = 4,
   parameter int HOLD_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   reg_mem_cmd_sequencer_if.slave bus,
   output logic [1:0]            opcode,
   output logic [2:0]            reg_addr,
   output logic [3:0]            mem_addr,
   output logic [31:0]           data,
   output logic                  issue,
   output logic                  busy,
   input  logic [31:0]           data_out,
   output logic [15:0]           cmd_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef struct packed {
      logic [1:0]  op;
      logic [2:0]  ra;
      logic [3:0]  ma;
      logic [31:0] d;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   cmd_t          fifo_q [DEPTH];
   cmd_t          fifo_d [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   state_t        state_q, state_d;
   cmd_t          cur_q, cur_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          issue_q, issue_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [1:0]    rsp_opcode_q, rsp_opcode_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic [15:0]   cmd_count_q, cmd_count_d;

   logic full, empty, push;
   cmd_t cmd_in;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign bus.cmd_ready = !rst && !full;
   assign push  = bus.cmd_valid && bus.cmd_ready;
   assign cmd_in = '{op: bus.cmd_opcode, ra: bus.cmd_reg_addr, ma: bus.cmd_mem_addr, d: bus.cmd_data};

   always_comb begin
      fifo_d       = fifo_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      state_d      = state_q;
      cur_d        = cur_q;
      cnt_d        = cnt_q;
      issue_d      = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_opcode_d = rsp_opcode_q;
      rsp_data_d   = rsp_data_q;
      cmd_count_d  = cmd_count_q;
      if (push) begin
         fifo_d[wptr_q[AW-1:0]] = cmd_in;
         wptr_d = wptr_q + PW'(1);
      end
      case (state_q)
         IDLE: if (!empty) begin
            cur_d   = fifo_q[rptr_q[AW-1:0]];
            rptr_d  = rptr_q + PW'(1);
            issue_d = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = CW'(HOLD_CYC - 1);
            state_d = WAIT;
         end
         WAIT: if (cnt_q == '0) begin
            if (!cur_q.op[1]) begin
               if (cmd_count_q != 16'hFFFF) cmd_count_d = cmd_count_q + 16'd1;
               state_d = IDLE;
            end else begin
               rsp_data_d   = data_out;
               rsp_opcode_d = cur_q.op;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
         RESP: if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            if (cmd_count_q != 16'hFFFF) cmd_count_d = cmd_count_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         state_q      <= IDLE;
         cur_q        <= '0;
         cnt_q        <= '0;
         issue_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_opcode_q <= '0;
         rsp_data_q   <= '0;
         cmd_count_q  <= '0;
      end else begin
         fifo_q       <= fifo_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         state_q      <= state_d;
         cur_q        <= cur_d;
         cnt_q        <= cnt_d;
         issue_q      <= issue_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_opcode_q <= rsp_opcode_d;
         rsp_data_q   <= rsp_data_d;
         cmd_count_q  <= cmd_count_d;
      end
   end

   assign opcode         = cur_q.op;
   assign reg_addr       = cur_q.ra;
   assign mem_addr       = cur_q.ma;
   assign data           = cur_q.d;
   assign issue          = issue_q;
   assign busy           = (state_q != IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_opcode = rsp_opcode_q;
   assign bus.rsp_data   = rsp_data_q;
   assign cmd_count      = cmd_count_q;
endmodule

// File: tb/tb_reg_mem_cmd_sequencer.sv
// Directed bench for reg_mem_cmd_sequencer with a transaction-level model of the
// command stream, a small unit/BRAM model, and per-cycle output comparison.
module tb_reg_mem_cmd_sequencer;
   localparam int DEPTH = 4;
   localparam int HOLD  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_mem_cmd_sequencer_if bus();
   logic [1:0]  opcode;
   logic [2:0]  reg_addr;
   logic [3:0]  mem_addr;
   logic [31:0] data, data_out;
   logic        issue, busy;
   logic [15:0] cmd_count;

   reg_mem_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_CYC(HOLD)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .opcode(opcode), .reg_addr(reg_addr), .mem_addr(mem_addr), .data(data),
      .issue(issue), .busy(busy), .data_out(data_out), .cmd_count(cmd_count)
   );

   // Unit model: 16-word memory, registers read back as 0x100+index.
   logic [31:0] bram [16];
   assign data_out = bram[mem_addr];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) bram[i] <= '0;
      end else if (issue) begin
         if (opcode == 2'd0) bram[mem_addr] <= data;
         else if (opcode == 2'd1) bram[mem_addr] <= 32'h100 + 32'(reg_addr);
      end
   end

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  ra;
      logic [3:0]  ma;
      logic [31:0] d;
   } mcmd_t;

   mcmd_t       q[$];
   logic [3:0]  iss_ma[$];
   int          wt = 0, rt = 0, rd = 0, since = 100;
   bit          rsp_wait = 0;
   logic [1:0]  exp_rop;
   logic [31:0] exp_rdata;
   logic [15:0] exp_cnt = '0;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Model: commands complete in acceptance order; writes count HOLD+1 cycles after
   // issue, reads present a response HOLD+1 cycles after issue and count after handshake.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         wt = 0; rt = 0; rd = 0; rsp_wait = 0; since = 100;
         exp_cnt = '0;
         chk("rst_issue", issue, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_cmd_count", cmd_count, 0);
         chk("rst_cmd_ready", bus.cmd_ready, 0);
      end else begin
         since++;
         if (wt > 0) begin wt--; if (wt == 0) exp_cnt = sat_inc(exp_cnt); end
         if (rt > 0) begin rt--; if (rt == 0) exp_cnt = sat_inc(exp_cnt); end
         chk("cmd_count", cmd_count, exp_cnt);
         if (rd > 0) begin
            rd--;
            if (rd == 0) begin
               rsp_wait = 1;
               chk("rsp_valid_due", bus.rsp_valid, 1);
               chk("rsp_opcode", bus.rsp_opcode, exp_rop);
               chk("rsp_data", bus.rsp_data, exp_rdata);
            end else begin
               chk("rsp_valid_early", bus.rsp_valid, 0);
            end
         end else if (rsp_wait) begin
            chk("rsp_valid_hold", bus.rsp_valid, 1);
            chk("rsp_opcode_hold", bus.rsp_opcode, exp_rop);
            chk("rsp_data_hold", bus.rsp_data, exp_rdata);
         end else begin
            chk("rsp_valid_idle", bus.rsp_valid, 0);
         end
         if (rsp_wait && bus.rsp_valid && bus.rsp_ready) begin
            rsp_wait = 0;
            rt = 1;
         end
         if (issue) begin
            chk("issue_gap", since >= HOLD + 2, 1);
            chk("issue_while_inflight", (rd > 0 || rsp_wait || wt > 0 || rt > 0), 0);
            chk("busy_at_issue", busy, 1);
            since = 0;
            if (q.size() == 0) begin
               chk("issue_unexpected", 0, 1);
            end else begin
               mcmd_t e;
               e = q.pop_front();
               chk("issue_opcode", opcode, e.op);
               chk("issue_reg_addr", reg_addr, e.ra);
               chk("issue_mem_addr", mem_addr, e.ma);
               chk("issue_data", data, e.d);
               iss_ma.push_back(e.ma);
               if (!e.op[1]) wt = HOLD + 1;
               else begin
                  rd = HOLD + 1;
                  exp_rop = e.op;
                  exp_rdata = bram[e.ma];
               end
            end
         end
         if (bus.cmd_valid && bus.cmd_ready)
            q.push_back('{op: bus.cmd_opcode, ra: bus.cmd_reg_addr, ma: bus.cmd_mem_addr, d: bus.cmd_data});
      end
   end

   // Drivers run at posedge+1; push returns at posedge+1 right after the accepting edge.
   task automatic push(input logic [1:0] op, input logic [2:0] ra, input logic [3:0] ma,
                       input logic [31:0] d, input bit keep);
      bit got = 0;
      bus.cmd_opcode = op; bus.cmd_reg_addr = ra; bus.cmd_mem_addr = ma; bus.cmd_data = d;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin got = 1; break; end
      end
      if (!got) chk("push_timeout", 0, 1);
      @(posedge clk); #1;
      if (!keep) bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_issue();
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (issue) begin got = 1; break; end
      end
      chk("issue_timeout", got, 1);
   endtask

   task automatic wait_count(input logic [15:0] target);
      bit got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cmd_count == target && !busy) begin got = 1; break; end
      end
      chk("count_timeout", got, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 0; bus.cmd_opcode = 0; bus.cmd_reg_addr = 0;
      bus.cmd_mem_addr = 0; bus.cmd_data = 0; bus.rsp_ready = 0;

      // Reset held 5 cycles
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_opcode", opcode, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_data", data, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      rst = 1'b0;
      #1 chk("ready_after_rst", bus.cmd_ready, 1);
      @(posedge clk); #1;

      // Single write: issue 2 cycles after accept, count 1 after HOLD+1 more
      push(2'd0, 3'd0, 4'd1, 32'd10, 0);
      @(negedge clk); chk("t2_no_issue_yet", issue, 0);
      @(negedge clk); chk("t2_issue", issue, 1);
      chk("t2_mem_addr", mem_addr, 1);
      chk("t2_data", data, 10);
      @(negedge clk); chk("t2_issue_one_cycle", issue, 0);
      @(negedge clk); chk("t2_count_pending", cmd_count, 0);
      @(negedge clk); chk("t2_count_done", cmd_count, 1);
      @(posedge clk); #1;

      // Display read with stalled consumer
      push(2'd3, 3'd0, 4'd1, 32'd0, 0);
      wait_issue();
      repeat (HOLD + 1) @(negedge clk);
      chk("t3_rsp_valid", bus.rsp_valid, 1);
      chk("t3_rsp_opcode", bus.rsp_opcode, 3);
      chk("t3_rsp_data", bus.rsp_data, 10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_data", bus.rsp_data, 10);
         chk("t3_hold_busy", busy, 1);
         chk("t3_hold_no_issue", issue, 0);
      end
      @(posedge clk); #1 bus.rsp_ready = 1'b1;
      @(posedge clk); #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("t3_rsp_dropped", bus.rsp_valid, 0);
      chk("t3_count", cmd_count, 2);
      @(posedge clk); #1;

      // FIFO fill while a read is stuck in response; cmd_valid held high
      iss_ma.delete();
      push(2'd3, 3'd0, 4'd2, 32'd0, 0);
      for (int i = 0; i < 4; i++) push(2'd0, 3'(i), 4'(i), 32'hA0 + 32'(i), 1);
      bus.cmd_opcode = 2'd0; bus.cmd_reg_addr = 3'd4; bus.cmd_mem_addr = 4'd4; bus.cmd_data = 32'hA4;
      @(negedge clk); chk("t4_full_ready", bus.cmd_ready, 0);
      @(negedge clk); chk("t4_full_ready2", bus.cmd_ready, 0);
      @(posedge clk); #1 bus.rsp_ready = 1'b1;
      push(2'd0, 3'd4, 4'd4, 32'hA4, 0);
      wait_count(16'd8);
      bus.rsp_ready = 1'b0;
      chk("t4_issued_n", iss_ma.size(), 6);
      if (iss_ma.size() == 6) begin
         chk("t4_order0", iss_ma[0], 2);
         for (int i = 0; i < 5; i++) chk("t4_order", iss_ma[i+1], i);
      end
      chk("t4_bram4", bram[4], 32'hA4);

      // Reset during WAIT of a read, with more commands buffered
      push(2'd2, 3'd3, 4'd5, 32'd0, 0);
      push(2'd0, 3'd0, 4'd6, 32'd99, 0);
      push(2'd0, 3'd0, 4'd7, 32'd77, 0);
      chk("t5_busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("t5_async_busy", busy, 0);
      chk("t5_async_issue", issue, 0);
      chk("t5_async_opcode", opcode, 0);
      chk("t5_async_mem_addr", mem_addr, 0);
      chk("t5_async_count", cmd_count, 0);
      chk("t5_async_ready", bus.cmd_ready, 0);
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("t5_no_issue", issue, 0);
         chk("t5_no_rsp", bus.rsp_valid, 0);
      end
      chk("t5_count", cmd_count, 0);
      chk("t5_ready", bus.cmd_ready, 1);
      @(posedge clk); #1;

      // Saturation from 0xFFFE
      force dut.cmd_count_q = 16'hFFFE;
      exp_cnt = 16'hFFFE;
      @(posedge clk); #1;
      release dut.cmd_count_q;
      @(negedge clk); chk("t6_preload", cmd_count, 16'hFFFE);
      @(posedge clk); #1;
      push(2'd0, 3'd0, 4'd8, 32'd1, 0);
      push(2'd1, 3'd5, 4'd9, 32'd2, 0);
      push(2'd0, 3'd0, 4'd10, 32'd3, 0);
      wait_count(16'hFFFF);
      repeat (10) @(negedge clk);
      chk("t6_saturated", cmd_count, 16'hFFFF);
      chk("t6_reg_to_mem", bram[9], 32'h105);
      chk("t6_model_empty", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
